// File: rtl/simon_pkg.sv
// Shared types and default constants for the Simon round controller.
package simon_pkg;

  localparam int unsigned COLOR_W         = 2;
  localparam int unsigned DEFAULT_MAX_LEN = 16;
  localparam int unsigned ON_TICKS        = 30;
  localparam int unsigned OFF_TICKS       = 30;
  localparam int unsigned TIMEOUT_TICKS   = 120;

  // Register widths: len counts 0..MAX_LEN, idx addresses the pattern,
  // cnt must hold the largest of the tick limits minus one.
  localparam int unsigned LEN_W = 5;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPEND,
    ST_PLAY_ON,
    ST_PLAY_OFF,
    ST_WAIT_BTN,
    ST_LOSE,
    ST_WIN
  } state_t;

endpackage

// File: rtl/simon_pattern_mem.sv
// Pattern storage: register file with one synchronous write port and one
// asynchronous read port. No reset; entries are always written before use.
module simon_pattern_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Synchronous write of one colour entry.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/simon_round_ctrl.sv
// Simon round sequencer: grows the pattern, plays it back with fixed on/off
// timing, then checks player presses against it with a per-press timeout.
module simon_round_ctrl #(
  parameter int unsigned MAX_LEN       = simon_pkg::DEFAULT_MAX_LEN,
  parameter int unsigned ON_TICKS      = simon_pkg::ON_TICKS,
  parameter int unsigned OFF_TICKS     = simon_pkg::OFF_TICKS,
  parameter int unsigned TIMEOUT_TICKS = simon_pkg::TIMEOUT_TICKS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [simon_pkg::COLOR_W-1:0] rand_num,
  input  logic                         btn_valid,
  input  logic [simon_pkg::COLOR_W-1:0] btn_num,
  output logic                         led_on,
  output logic [simon_pkg::COLOR_W-1:0] led_num,
  output logic                         player_turn,
  output logic                         game_over,
  output logic                         win,
  output logic [simon_pkg::LEN_W-1:0]   score
);

  import simon_pkg::*;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  state_t             state, state_nx;
  logic [LEN_W-1:0]   len, len_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [LEN_W-1:0]   score_q, score_nx;
  logic               mem_we;
  logic [COLOR_W-1:0] mem_rdata;
  logic               idx_last;

  simon_pattern_mem #(
    .DEPTH (MAX_LEN),
    .AW    (IDX_W),
    .WIDTH (COLOR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (len[IDX_W-1:0]),
    .wdata (rand_num),
    .raddr (idx),
    .rdata (mem_rdata)
  );

  assign idx_last = ({1'b0, idx} == (len - LEN_W'(1)));

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      len     <= '0;
      idx     <= '0;
      cnt     <= '0;
      score_q <= '0;
    end else begin
      state   <= state_nx;
      len     <= len_nx;
      idx     <= idx_nx;
      cnt     <= cnt_nx;
      score_q <= score_nx;
    end
  end

  // Next-state and datapath update; cnt is cleared on every state change.
  always_comb begin
    state_nx = state;
    len_nx   = len;
    idx_nx   = idx;
    cnt_nx   = cnt;
    score_nx = score_q;
    mem_we   = 1'b0;
    unique case (state)
      ST_IDLE, ST_LOSE, ST_WIN: begin
        if (start) begin
          len_nx   = '0;
          idx_nx   = '0;
          score_nx = '0;
          state_nx = ST_APPEND;
        end
      end
      ST_APPEND: begin
        mem_we   = 1'b1;
        len_nx   = len + LEN_W'(1);
        idx_nx   = '0;
        cnt_nx   = '0;
        state_nx = ST_PLAY_ON;
      end
      ST_PLAY_ON: begin
        if (cnt == ON_LAST) begin
          cnt_nx   = '0;
          state_nx = ST_PLAY_OFF;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_PLAY_OFF: begin
        if (cnt == OFF_LAST) begin
          cnt_nx = '0;
          if (idx_last) begin
            idx_nx   = '0;
            state_nx = ST_WAIT_BTN;
          end else begin
            idx_nx   = idx + IDX_W'(1);
            state_nx = ST_PLAY_ON;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_WAIT_BTN: begin
        // A press takes priority over a timeout expiring in the same cycle.
        if (btn_valid) begin
          cnt_nx = '0;
          if (btn_num == mem_rdata) begin
            if (idx_last) begin
              score_nx = len;
              state_nx = (len == LEN_MAX) ? ST_WIN : ST_APPEND;
            end else begin
              idx_nx = idx + IDX_W'(1);
            end
          end else begin
            state_nx = ST_LOSE;
          end
        end else if (cnt == TO_LAST) begin
          cnt_nx   = '0;
          state_nx = ST_LOSE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign led_on      = (state == ST_PLAY_ON);
  assign led_num     = ((state == ST_PLAY_ON) || (state == ST_PLAY_OFF)) ? mem_rdata : '0;
  assign player_turn = (state == ST_WAIT_BTN);
  assign game_over   = (state == ST_LOSE) || (state == ST_WIN);
  assign win         = (state == ST_WIN);
  assign score       = score_q;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Directed bench for simon_round_ctrl: default build for playback, timing,
// timeout and reset behaviour; a MAX_LEN=3 short-tick build for the win path.
module tb_simon_round_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, btn_valid;
  logic [1:0] rand_num, btn_num;
  logic       led_on, player_turn, game_over, win;
  logic [1:0] led_num;
  logic [4:0] score;

  logic       start2, btn_valid2;
  logic [1:0] rand2, btn_num2;
  logic       led_on2, player_turn2, game_over2, win2;
  logic [1:0] led_num2;
  logic [4:0] score2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  simon_round_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rand_num    (rand_num),
    .btn_valid   (btn_valid),
    .btn_num     (btn_num),
    .led_on      (led_on),
    .led_num     (led_num),
    .player_turn (player_turn),
    .game_over   (game_over),
    .win         (win),
    .score       (score)
  );

  simon_round_ctrl #(
    .MAX_LEN       (3),
    .ON_TICKS      (4),
    .OFF_TICKS     (3),
    .TIMEOUT_TICKS (10)
  ) dut2 (
    .clk         (clk),
    .reset       (reset),
    .start       (start2),
    .rand_num    (rand2),
    .btn_valid   (btn_valid2),
    .btn_num     (btn_num2),
    .led_on      (led_on2),
    .led_num     (led_num2),
    .player_turn (player_turn2),
    .game_over   (game_over2),
    .win         (win2),
    .score       (score2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] num);
    btn_valid = 1'b1;
    btn_num   = num;
    tick(1);
    btn_valid = 1'b0;
  endtask

  task automatic press2(input logic [1:0] num);
    btn_valid2 = 1'b1;
    btn_num2   = num;
    tick(1);
    btn_valid2 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] pat [3];
    pat[0] = 2'd1; pat[1] = 2'd2; pat[2] = 2'd3;

    reset = 1'b1; start = 1'b0; btn_valid = 1'b0; rand_num = 2'd0; btn_num = 2'd0;
    start2 = 1'b0; btn_valid2 = 1'b0; rand2 = 2'd0; btn_num2 = 2'd0;
    tick(3);
    reset = 1'b0;
    chk("rst_led_on", led_on, 0);
    chk("rst_led_num", led_num, 0);
    chk("rst_player_turn", player_turn, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_win", win, 0);
    chk("rst_score", score, 0);

    // Round 1: start in cycle 0 with rand_num=2.
    start = 1'b1; rand_num = 2'd2;
    tick(1);
    start = 1'b0;
    chk("append_led_on", led_on, 0);
    tick(1);
    // Cycles 2..61; stray start/btn pulses at cycles 10 and 40 must be ignored.
    for (int c = 2; c < 62; c++) begin
      chk("r1_led_on", led_on, (c < 32) ? 1 : 0);
      chk("r1_led_num", led_num, 2);
      chk("r1_player_turn", player_turn, 0);
      if (c == 10 || c == 40) begin
        start = 1'b1; btn_valid = 1'b1; btn_num = 2'd2;
      end else begin
        start = 1'b0; btn_valid = 1'b0;
      end
      tick(1);
    end
    chk("r1_turn_c62", player_turn, 1);
    chk("r1_led_off_c62", led_on, 0);

    // Correct press at cycle 62; next APPEND samples rand_num=0.
    rand_num = 2'd0;
    press(2'd2);
    chk("r1_score", score, 1);
    chk("r1_append_turn", player_turn, 0);
    chk("r1_append_led", led_on, 0);
    tick(1);
    // Round 2 playback [2,0]: cycles 64..183.
    for (int k = 0; k < 120; k++) begin
      chk("r2_led_on", led_on, ((k % 60) < 30) ? 1 : 0);
      chk("r2_led_num", led_num, (k < 60) ? 2 : 0);
      chk("r2_player_turn", player_turn, 0);
      tick(1);
    end
    chk("r2_turn_c184", player_turn, 1);

    // Accepted press at cnt=100 restarts the timeout.
    tick(100);
    chk("r2_turn_cnt100", player_turn, 1);
    press(2'd2);
    tick(110);
    chk("r2_turn_after_restart", player_turn, 1);
    chk("r2_no_lose_yet", game_over, 0);
    press(2'd1);
    chk("lose_game_over", game_over, 1);
    chk("lose_win", win, 0);
    chk("lose_score", score, 1);
    chk("lose_turn", player_turn, 0);
    press(2'd0);
    tick(3);
    chk("lose_hold", game_over, 1);

    // New game from LOSE; let the turn time out.
    start = 1'b1; rand_num = 2'd1;
    tick(1);
    start = 1'b0;
    chk("restart_score", score, 0);
    chk("restart_game_over", game_over, 0);
    tick(61);
    chk("to_turn_c62", player_turn, 1);
    tick(119);
    chk("to_turn_cnt119", player_turn, 1);
    chk("to_no_lose_cnt119", game_over, 0);
    tick(1);
    chk("to_game_over", game_over, 1);
    chk("to_win", win, 0);
    chk("to_turn", player_turn, 0);

    // Matching press exactly at cnt=119 is accepted.
    start = 1'b1; rand_num = 2'd3;
    tick(1);
    start = 1'b0;
    tick(61);
    tick(119);
    rand_num = 2'd1;
    press(2'd3);
    chk("edge_press_game_over", game_over, 0);
    chk("edge_press_score", score, 1);
    chk("edge_press_turn", player_turn, 0);
    tick(6);
    chk("r2b_led_on", led_on, 1);
    chk("r2b_led_num", led_num, 3);

    // Asynchronous reset during round-2 playback.
    reset = 1'b1;
    #1;
    chk("midrst_led_on", led_on, 0);
    chk("midrst_led_num", led_num, 0);
    chk("midrst_score", score, 0);
    chk("midrst_turn", player_turn, 0);
    chk("midrst_game_over", game_over, 0);
    chk("midrst_win", win, 0);
    tick(1);
    reset = 1'b0; start = 1'b1; rand_num = 2'd2;
    tick(1);
    start = 1'b0;
    chk("postrst_append_led", led_on, 0);
    tick(1);
    chk("postrst_led_on", led_on, 1);
    chk("postrst_led_num", led_num, 2);

    // MAX_LEN=3 build with pattern [1,2,3].
    start2 = 1'b1; rand2 = pat[0];
    tick(1);
    start2 = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      tick(1 + 7 * r);
      chk("w_turn", player_turn2, 1);
      for (int i = 0; i < r; i++) begin
        if (i == r - 1 && r < 3) rand2 = pat[r];
        press2(pat[i]);
      end
      chk("w_score", score2, r);
      chk("w_game_over", game_over2, (r == 3) ? 1 : 0);
      chk("w_win", win2, (r == 3) ? 1 : 0);
    end
    tick(3);
    chk("win_hold", win2, 1);
    chk("win_hold_score", score2, 3);
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    chk("win_restart_score", score2, 0);
    chk("win_restart_win", win2, 0);
    chk("win_restart_game_over", game_over2, 0);
    tick(8);
    chk("win_restart_turn", player_turn2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
